logic_gate_unit: RTL and testbench

Parametrised, registered N-input, W-bit logic gate with a runtime-selectable function (AND/OR/NAND/NOR/XOR/XNOR/BUF/NOT). It is the next generation of the team's single-bit two-input gate cells. It uses a valid/ready handshake with one output register. A built-in sweep sequencer drives every input combination through the gate to produce a truth table in hardware.

---
 rtl/logic_gate_unit.sv | 193 +++++++++++++++++++
 tb/tb_logic_gate_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// logic_gate_unit
//   Registered NUM_IN-operand, WIDTH-bit bitwise logic gate with a runtime
//   function select, a valid/ready handshake around a single output register,
//   and a built-in sweep sequencer that walks every operand combination
//   through the gate to emit a truth table.
//
// Parameters
//   WIDTH   bit width of each operand and of the result (1..32)
//   NUM_IN  number of operands (2..8)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   op           000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR,
//                110 BUF(operand0), 111 NOT(operand0)
//   in_valid     in_data/op valid
//   in_ready     unit accepts input this cycle
//   in_data      operand k = in_data[k*WIDTH +: WIDTH]
//   out_valid    out_y valid
//   out_ready    downstream accepts out_y
//   out_y        registered result
//   sweep_start  single-cycle pulse, starts the truth-table sweep (IDLE only)
//   sweep_busy   sweep in progress
//   sweep_done   one-cycle pulse after the last sweep vector is accepted
//   xfer_count   (LGU_STATS_EN only) saturating count of output transfers
//
// Build option
//   LGU_STATS_EN  when defined, adds the 16-bit xfer_count output port.

module logic_gate_unit #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               op,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    input  logic                     sweep_start,
    output logic                     sweep_busy,
    output logic                     sweep_done
`ifdef LGU_STATS_EN
    ,
    output logic [15:0]              xfer_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DONE
    } state_t;

    // Counter value of the final sweep vector (2^NUM_IN - 1).
    localparam logic [NUM_IN:0] LAST_VEC = {1'b0, {NUM_IN{1'b1}}};

    state_t                    state;
    state_t                    state_nxt;
    logic [2:0]                op_s;
    logic [NUM_IN:0]           cnt;

    logic                      can_load;
    logic                      load;
    logic [2:0]                sel_op;
    logic [NUM_IN*WIDTH-1:0]   sel_data;
    logic [WIDTH-1:0]          acc_and;
    logic [WIDTH-1:0]          acc_or;
    logic [WIDTH-1:0]          acc_xor;
    logic [WIDTH-1:0]          gate_y;

    // Output register can take a new value when empty or draining this cycle.
    assign can_load = !out_valid || out_ready;
    assign in_ready = !sweep_busy && can_load;
    assign load     = sweep_busy ? can_load : (in_valid && in_ready);

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sweep_busy = 1'b0;
        sweep_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (sweep_start) begin
                    state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                sweep_busy = 1'b1;
                if (can_load && (cnt == LAST_VEC)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                sweep_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_s <= '0;
            cnt  <= '0;
        end else if ((state == S_IDLE) && sweep_start) begin
            op_s <= op;
            cnt  <= '0;
        end else if (sweep_busy && can_load) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Operand source: external bus, or the sweep counter with bit k of
    // the counter replicated across operand k.
    // ------------------------------------------------------------------
    always_comb begin
        sel_op   = op;
        sel_data = in_data;
        if (sweep_busy) begin
            sel_op = op_s;
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                sel_data[k*WIDTH +: WIDTH] = {WIDTH{cnt[k]}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Bitwise gate across all operands
    // ------------------------------------------------------------------
    always_comb begin
        acc_and = '1;
        acc_or  = '0;
        acc_xor = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            acc_and = acc_and & sel_data[k*WIDTH +: WIDTH];
            acc_or  = acc_or  | sel_data[k*WIDTH +: WIDTH];
            acc_xor = acc_xor ^ sel_data[k*WIDTH +: WIDTH];
        end
        case (sel_op)
            3'b000:  gate_y = acc_and;
            3'b001:  gate_y = acc_or;
            3'b010:  gate_y = ~acc_and;
            3'b011:  gate_y = ~acc_or;
            3'b100:  gate_y = acc_xor;
            3'b101:  gate_y = ~acc_xor;
            3'b110:  gate_y = sel_data[WIDTH-1:0];
            default: gate_y = ~sel_data[WIDTH-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_y     <= gate_y;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef LGU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready && (xfer_count != 16'hFFFF)) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
module tb_logic_gate_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: NUM_IN=2
    logic [2:0]  op_a = '0;
    logic        iv_a = 1'b0;
    logic        ir_a;
    logic [15:0] d_a = '0;
    logic        ov_a;
    logic        or_a = 1'b1;
    logic [7:0]  y_a;
    logic        ss_a = 1'b0;
    logic        busy_a;
    logic        done_a;

    // Instance B: NUM_IN=3
    logic [2:0]  op_b = '0;
    logic        iv_b = 1'b0;
    logic        ir_b;
    logic [23:0] d_b = '0;
    logic        ov_b;
    logic        or_b = 1'b1;
    logic [7:0]  y_b;
    logic        busy_b;
    logic        done_b;

`ifdef LGU_STATS_EN
    logic [15:0] xc_a;
    logic [15:0] xc_b;
`endif

    logic_gate_unit #(.WIDTH(8), .NUM_IN(2)) u_a (
        .clk(clk), .rst_n(rst_n), .op(op_a), .in_valid(iv_a), .in_ready(ir_a),
        .in_data(d_a), .out_valid(ov_a), .out_ready(or_a), .out_y(y_a),
        .sweep_start(ss_a), .sweep_busy(busy_a), .sweep_done(done_a)
`ifdef LGU_STATS_EN
        , .xfer_count(xc_a)
`endif
    );

    logic_gate_unit #(.WIDTH(8), .NUM_IN(3)) u_b (
        .clk(clk), .rst_n(rst_n), .op(op_b), .in_valid(iv_b), .in_ready(ir_b),
        .in_data(d_b), .out_valid(ov_b), .out_ready(or_b), .out_y(y_b),
        .sweep_start(1'b0), .sweep_busy(busy_b), .sweep_done(done_b)
`ifdef LGU_STATS_EN
        , .xfer_count(xc_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: per bit position, count the ones among the n operands and
    // decide the result from that count.
    function automatic logic [7:0] ref_gate(input logic [2:0] f, input logic [63:0] data, input int n);
        logic [7:0] r;
        int ones;
        logic b0;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int k = 0; k < n; k++) ones += int'(data[k*8 + b]);
            b0 = data[b];
            case (f)
                3'd0:    r[b] = (ones == n);
                3'd1:    r[b] = (ones > 0);
                3'd2:    r[b] = (ones != n);
                3'd3:    r[b] = (ones == 0);
                3'd4:    r[b] = (ones % 2 == 1);
                3'd5:    r[b] = (ones % 2 == 0);
                3'd6:    r[b] = b0;
                default: r[b] = !b0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_sweep(input logic [2:0] f, input int c, input int n);
        logic [63:0] data;
        data = '0;
        for (int k = 0; k < n; k++) data[k*8 +: 8] = ((c >> k) & 1) != 0 ? 8'hFF : 8'h00;
        return ref_gate(f, data, n);
    endfunction

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    logic [7:0] q[$];
    logic [7:0] exp_seq[$];
    int idx;
    int done_cnt;
    int done_at;
    logic [7:0] first_y;
    logic exp_ready;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_out_valid", 32'(ov_a), 32'd0);
        check("rst_out_y", 32'(y_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(ir_a), 32'd1);

        // ---------------- test 1: NOR, latency 1 ----------------
        op_a = 3'b011; d_a = {8'h30, 8'h0F}; iv_a = 1'b1; or_a = 1'b1;
        #1 check("t1_ready", 32'(ir_a), 32'd1);
        check("t1_pre_valid", 32'(ov_a), 32'd0);
        tick();
        iv_a = 1'b0;
        check("t1_valid", 32'(ov_a), 32'd1);
        check("t1_y", 32'(y_a), 32'(ref_gate(3'b011, 64'(d_a), 2)));
        check("t1_y_const", 32'(y_a), 32'hC0);
        tick();
        check("t1_valid_drop", 32'(ov_a), 32'd0);

        // ---------------- test 2: backpressure ----------------
        or_a = 1'b0; op_a = 3'b000; d_a = {8'hFF, 8'h3C}; iv_a = 1'b1;
        tick();
        op_a = 3'b001; d_a = {8'h01, 8'h02};
        #1 check("t2_ready_low", 32'(ir_a), 32'd0);
        check("t2_y", 32'(y_a), 32'h3C);
        tick();
        check("t2_hold_y", 32'(y_a), 32'h3C);
        check("t2_hold_valid", 32'(ov_a), 32'd1);
        or_a = 1'b1;
        #1 check("t2_ready_high", 32'(ir_a), 32'd1);
        tick();
        iv_a = 1'b0;
        check("t2_second_y", 32'(y_a), 32'(ref_gate(3'b001, 64'h0102, 2)));
        check("t2_second_valid", 32'(ov_a), 32'd1);
        tick();
        check("t2_drained", 32'(ov_a), 32'd0);

        // ---------------- test 3: sweep NUM_IN=2, NOR ----------------
        exp_seq.delete();
        for (int c = 0; c < 4; c++) exp_seq.push_back(ref_sweep(3'b011, c, 2));
        op_a = 3'b011; ss_a = 1'b1;
        tick();
        ss_a = 1'b0; op_a = 3'b000;            // op change during sweep has no effect
        iv_a = 1'b1; d_a = 16'h5A5A;           // external input must be ignored
        check("t3_busy", 32'(busy_a), 32'd1);
        idx = 0; done_cnt = 0; done_at = -1;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) check("t3_ready_busy", 32'(ir_a), 32'd0);
            if (ov_a && or_a) begin
                if (idx < 4) check("t3_seq", 32'(y_a), 32'(exp_seq[idx]));
                idx++;
            end
            if (done_a) begin
                done_cnt++;
                done_at = idx;
                check("t3_busy_in_done", 32'(busy_a), 32'd0);
                iv_a = 1'b0;
            end
            tick();
        end
        iv_a = 1'b0;
        check("t3_out_count", 32'(idx), 32'd4);
        check("t3_done_count", 32'(done_cnt), 32'd1);
        check("t3_done_timing", 32'(done_at), 32'd4);
        check("t3_idle_valid", 32'(ov_a), 32'd0);

        // ---------------- test 4: NUM_IN=3 XOR / XNOR ----------------
        or_b = 1'b1; iv_b = 1'b1; op_b = 3'b100; d_b = {8'hF0, 8'hCC, 8'hAA};
        tick();
        op_b = 3'b101;
        check("t4_xor", 32'(y_b), 32'h96);
        check("t4_xor_model", 32'(y_b), 32'(ref_gate(3'b100, 64'(d_b), 3)));
        tick();
        iv_b = 1'b0;
        check("t4_xnor", 32'(y_b), 32'h69);
        tick();

        // ---------------- random traffic on NUM_IN=3 ----------------
        q.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            iv_b = 1'($urandom_range(0, 1));
            or_b = ($urandom_range(0, 3) != 0);
            op_b = 3'($urandom_range(0, 7));
            d_b  = 24'($urandom);
            #1;
            exp_ready = (q.size() == 0) || or_b;
            check("rnd_valid", 32'(ov_b), 32'(q.size() != 0));
            check("rnd_ready", 32'(ir_b), 32'(exp_ready));
            if (q.size() != 0 && or_b) check("rnd_y", 32'(y_b), 32'(q.pop_front()));
            if (iv_b && exp_ready) q.push_back(ref_gate(op_b, 64'(d_b), 3));
        end
        iv_b = 1'b0; or_b = 1'b1;
        tick(); tick();
        check("rnd_drain", 32'(ov_b), 32'd0);

        // ---------------- test 5: reset mid-sweep ----------------
        or_a = 1'b1; op_a = 3'b011; ss_a = 1'b1;
        tick();
        ss_a = 1'b0;
        idx = 0;
        for (int i = 0; i < 10 && idx < 2; i++) begin
            tick();
            if (ov_a) idx++;
        end
        check("t5_two_vectors", 32'(idx), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(ov_a), 32'd0);
        check("t5_rst_busy", 32'(busy_a), 32'd0);
        check("t5_rst_done", 32'(done_a), 32'd0);
        check("t5_rst_y", 32'(y_a), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`ifdef LGU_STATS_EN
        check("t6_count_reset", 32'(xc_a), 32'd0);
`endif
        op_a = 3'b011; ss_a = 1'b1;
        tick();
        ss_a = 1'b0;
        idx = 0; done_cnt = 0; first_y = 8'h00;
        for (int i = 0; i < 12; i++) begin
            if (ov_a) begin
                if (idx == 0) first_y = y_a;
                idx++;
            end
            if (done_a) done_cnt++;
            tick();
        end
        check("t5_restart_first", 32'(first_y), 32'(ref_sweep(3'b011, 0, 2)));
        check("t5_restart_count", 32'(idx), 32'd4);
        check("t5_restart_done", 32'(done_cnt), 32'd1);

`ifdef LGU_STATS_EN
        // ---------------- test 6: transfer counter ----------------
        iv_a = 1'b1; op_a = 3'b000; d_a = 16'hFFFF;
        tick();
        iv_a = 1'b0;
        tick(); tick();
        check("t6_count5", 32'(xc_a), 32'd5);
        iv_a = 1'b1;
        repeat (65600) @(posedge clk);
        tick();
        check("t6_saturate", 32'(xc_a), 32'hFFFF);
        tick(); tick();
        iv_a = 1'b0;
        check("t6_hold", 32'(xc_a), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
